// File: rtl/des_key_schedule.sv
// DES round-subkey generator: forward K1..K16, precalc pass to K16, reverse K16..K1.
// Optional macro DES_KS_FAST_PRECALC_EN collapses PRECALC to one cycle (C16D16 == C0D0).
module des_key_schedule #(
  parameter int KEY_W    = 64,
  parameter int SUBKEY_W = 48
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEY_W-1:0]    key_in,
  input  logic                key_load,
  input  logic                key_process,
  input  logic                encipher_process,
  input  logic                decipher_process,
  output logic [SUBKEY_W-1:0] subkey,
  output logic                subkey_valid,
  output logic [4:0]          round_num,
  output logic                k16_complete,
  output logic                ks_busy
);

  typedef enum logic [2:0] {IDLE, ENC_RUN, PRECALC, DEC_READY, DEC_RUN} state_e;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Tables use DES numbering: bit 1 is the MSB of the vector.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[6'(64 - PC1_T[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[6'(56 - PC2_T[i])];
    return r;
  endfunction

  function automatic logic shift_two(input logic [4:0] n);
    return !(n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16);
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_e               state_q;
  logic [27:0]          c_q, d_q;
  logic [4:0]           cnt_q;
  logic [SUBKEY_W-1:0]  subkey_q;
  logic                 valid_q, k16_q;
  logic [4:0]           round_q;

  logic [4:0]  step_d;
  logic        fwd_two_d, rev_two_d;
  logic [27:0] c_fwd_d, d_fwd_d, c_rev_d, d_rev_d, c_end_d, d_end_d;

  always_comb begin
    step_d    = cnt_q + 5'd1;
    fwd_two_d = shift_two(step_d);
    rev_two_d = shift_two(5'd18 - step_d);
    c_fwd_d   = rotl(c_q, fwd_two_d);
    d_fwd_d   = rotl(d_q, fwd_two_d);
    c_rev_d   = rotr(c_q, rev_two_d);
    d_rev_d   = rotr(d_q, rev_two_d);
    // After K1 is issued, undo S[1] so the pass leaves C0,D0 behind.
    c_end_d   = rotr(c_rev_d, 1'b0);
    d_end_d   = rotr(d_rev_d, 1'b0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      c_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      subkey_q <= '0;
      valid_q  <= 1'b0;
      round_q  <= '0;
      k16_q    <= 1'b0;
    end else if (key_load) begin
      state_q    <= IDLE;
      {c_q, d_q} <= pc1(key_in);
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      round_q    <= '0;
      k16_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      round_q <= '0;
      k16_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_process && encipher_process) begin
            state_q <= ENC_RUN;
            cnt_q   <= '0;
          end else if (key_process && !decipher_process) begin
            state_q <= PRECALC;
            cnt_q   <= '0;
          end
        end
        ENC_RUN: begin
          c_q      <= c_fwd_d;
          d_q      <= d_fwd_d;
          subkey_q <= pc2({c_fwd_d, d_fwd_d});
          valid_q  <= 1'b1;
          round_q  <= step_d;
          cnt_q    <= step_d;
          if (step_d == 5'd16) begin
            k16_q   <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        PRECALC: begin
          if (!key_process) begin
            state_q <= IDLE;
          end else begin
`ifdef DES_KS_FAST_PRECALC_EN
            k16_q   <= 1'b1;
            state_q <= DEC_READY;
            cnt_q   <= '0;
`else
            c_q   <= c_fwd_d;
            d_q   <= d_fwd_d;
            cnt_q <= step_d;
            if (step_d == 5'd16) begin
              k16_q   <= 1'b1;
              state_q <= DEC_READY;
              cnt_q   <= '0;
            end
`endif
          end
        end
        DEC_READY: begin
          if (!key_process) begin
            state_q <= IDLE;
          end else if (decipher_process && !encipher_process) begin
            state_q <= DEC_RUN;
            cnt_q   <= '0;
          end
        end
        DEC_RUN: begin
          valid_q <= 1'b1;
          round_q <= step_d;
          cnt_q   <= step_d;
          if (cnt_q == 5'd0) begin
            subkey_q <= pc2({c_q, d_q});
          end else begin
            subkey_q <= pc2({c_rev_d, d_rev_d});
            if (step_d == 5'd16) {c_q, d_q} <= {c_end_d, d_end_d};
            else                 {c_q, d_q} <= {c_rev_d, d_rev_d};
          end
          if (step_d == 5'd16) begin
            k16_q   <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign subkey       = subkey_q;
  assign subkey_valid = valid_q;
  assign round_num    = round_q;
  assign k16_complete = k16_q;
  assign ks_busy      = (state_q != IDLE);

`ifndef SYNTHESIS
  a_proc_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(encipher_process && decipher_process));
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 133457799BBCDFF1 subkey table.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] key_in = '0;
  logic        key_load = 1'b0;
  logic        key_process = 1'b0;
  logic        encipher_process = 1'b0;
  logic        decipher_process = 1'b0;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [4:0]  round_num;
  logic        k16_complete;
  logic        ks_busy;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'hFFFFFFFFFFFFFFFF;

  logic [47:0] kt [16] = '{
    48'b000110_110000_001011_101111_111111_000111_000001_110010,
    48'b011110_011010_111011_011001_110110_111100_100111_100101,
    48'b010101_011111_110010_001010_010000_101100_111110_011001,
    48'b011100_101010_110111_010110_110110_110011_010100_011101,
    48'b011111_001110_110000_000111_111010_110101_001110_101000,
    48'b011000_111010_010100_111110_010100_000111_101100_101111,
    48'b111011_001000_010010_110111_111101_100001_100010_111100,
    48'b111101_111000_101000_111010_110000_010011_101111_111011,
    48'b111000_001101_101111_101011_111011_011110_011110_000001,
    48'b101100_011111_001101_000111_101110_100100_011001_001111,
    48'b001000_010101_111111_010011_110111_101101_001110_000110,
    48'b011101_010111_000111_110101_100101_000110_011111_101001,
    48'b100101_111100_010111_010001_111110_101011_101001_000001,
    48'b010111_110100_001110_110111_111100_101110_011100_111010,
    48'b101111_111001_000110_001101_001111_010011_111100_001010,
    48'b110010_110011_110110_001011_000011_100001_011111_110101};

  des_key_schedule dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .key_in           (key_in),
    .key_load         (key_load),
    .key_process      (key_process),
    .encipher_process (encipher_process),
    .decipher_process (decipher_process),
    .subkey           (subkey),
    .subkey_valid     (subkey_valid),
    .round_num        (round_num),
    .k16_complete     (k16_complete),
    .ks_busy          (ks_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic enc_run(input string tg);
    encipher_process = 1'b1;
    key_process      = 1'b1;
    tick();
    encipher_process = 1'b0;
    key_process      = 1'b0;
    chk({tg, "_busy"}, 64'(ks_busy), 64'd1);
    chk({tg, "_pre_vld"}, 64'(subkey_valid), 64'd0);
    for (int n = 1; n <= 16; n++) begin
      tick();
      chk($sformatf("%s_k%0d", tg, n), 64'(subkey), 64'(kt[n-1]));
      chk($sformatf("%s_rnd%0d", tg, n), 64'(round_num), 64'(n));
      chk($sformatf("%s_vld%0d", tg, n), 64'(subkey_valid), 64'd1);
      chk($sformatf("%s_k16_%0d", tg, n), 64'(k16_complete), 64'(n == 16));
    end
    tick();
    chk({tg, "_post_vld"}, 64'(subkey_valid), 64'd0);
    chk({tg, "_post_rnd"}, 64'(round_num), 64'd0);
    chk({tg, "_post_k16"}, 64'(k16_complete), 64'd0);
    chk({tg, "_post_hold"}, 64'(subkey), 64'(kt[15]));
    chk({tg, "_post_busy"}, 64'(ks_busy), 64'd0);
  endtask

  // Assumes key_process is already high and state is IDLE about to enter PRECALC.
  task automatic wait_precalc(input string tg);
    int  cyc;
    logic seen;
    cyc  = 0;
    seen = 1'b0;
    tick();
    for (int i = 0; i < 24 && !seen; i++) begin
      tick();
      cyc++;
      if (subkey_valid) chk({tg, "_pc_vld"}, 64'(subkey_valid), 64'd0);
      if (k16_complete) seen = 1'b1;
    end
    chk({tg, "_pc_done"}, 64'(seen), 64'd1);
`ifdef DES_KS_FAST_PRECALC_EN
    chk({tg, "_pc_len"}, 64'(cyc), 64'd1);
`else
    chk({tg, "_pc_len"}, 64'(cyc), 64'd16);
`endif
  endtask

  initial begin
    logic seen;
    #2;
    chk("rst_subkey", 64'(subkey), 64'd0);
    chk("rst_vld",    64'(subkey_valid), 64'd0);
    chk("rst_rnd",    64'(round_num), 64'd0);
    chk("rst_k16",    64'(k16_complete), 64'd0);
    chk("rst_busy",   64'(ks_busy), 64'd0);
    chk("rst_cd",     64'({dut.c_q, dut.d_q}), 64'd0);
    #10 rst_n = 1'b1;
    tick();

    // Encipher, then a second pass without reload.
    load(KEY_A);
    chk("c0d0", 64'({dut.c_q, dut.d_q}), 64'h00F0CCAAF556678F);
    enc_run("enc");
    chk("enc_cd_back", 64'({dut.c_q, dut.d_q}), 64'h00F0CCAAF556678F);
    enc_run("enc2");

    // Decipher: precalc then reverse order.
    key_process = 1'b1;
    wait_precalc("dec");
    tick();
    chk("dr_k16",  64'(k16_complete), 64'd0);
    chk("dr_busy", 64'(ks_busy), 64'd1);
    chk("dr_vld",  64'(subkey_valid), 64'd0);
    decipher_process = 1'b1;
    tick();
    decipher_process = 1'b0;
    key_process      = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("dec_k%0d", i), 64'(subkey), 64'(kt[16-i]));
      chk($sformatf("dec_rnd%0d", i), 64'(round_num), 64'(i));
      chk($sformatf("dec_vld%0d", i), 64'(subkey_valid), 64'd1);
      chk($sformatf("dec_k16_%0d", i), 64'(k16_complete), 64'(i == 16));
    end
    tick();
    chk("dec_post_vld",  64'(subkey_valid), 64'd0);
    chk("dec_post_busy", 64'(ks_busy), 64'd0);
    chk("dec_cd_back",   64'({dut.c_q, dut.d_q}), 64'h00F0CCAAF556678F);

    // Abort at round 7 with a new key; restart yields the new K1.
    load(KEY_A);
    encipher_process = 1'b1;
    key_process      = 1'b1;
    tick();
    encipher_process = 1'b0;
    key_process      = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("ab_rnd7", 64'(round_num), 64'd7);
    key_in           = KEY_B;
    key_load         = 1'b1;
    encipher_process = 1'b1;
    key_process      = 1'b1;
    tick();
    key_load = 1'b0;
    chk("ab_vld",  64'(subkey_valid), 64'd0);
    chk("ab_rnd",  64'(round_num), 64'd0);
    chk("ab_busy", 64'(ks_busy), 64'd0);
    tick();
    encipher_process = 1'b0;
    key_process      = 1'b0;
    tick();
    chk("ab_k1",   64'(subkey), 64'h0000FFFFFFFFFFFF);
    chk("ab_rnd1", 64'(round_num), 64'd1);
    chk("ab_vld1", 64'(subkey_valid), 64'd1);
    for (int i = 0; i < 15; i++) tick();
    chk("ab_k16",    64'(subkey), 64'h0000FFFFFFFFFFFF);
    chk("ab_k16_pl", 64'(k16_complete), 64'd1);
    tick();

    // Idle guard: drop key_process in DEC_READY.
    load(KEY_A);
    key_process = 1'b1;
    wait_precalc("ig");
    key_process = 1'b0;
    tick();
    chk("ig_idle", 64'(ks_busy), 64'd0);
    decipher_process = 1'b1;
    tick();
    tick();
    chk("ig_vld",  64'(subkey_valid), 64'd0);
    chk("ig_busy", 64'(ks_busy), 64'd0);
    decipher_process = 1'b0;
    tick();

    // Reset in the middle of an encipher run.
    load(KEY_A);
    encipher_process = 1'b1;
    key_process      = 1'b1;
    tick();
    encipher_process = 1'b0;
    key_process      = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mr_vld_pre", 64'(subkey_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_subkey", 64'(subkey), 64'd0);
    chk("mr_vld",    64'(subkey_valid), 64'd0);
    chk("mr_rnd",    64'(round_num), 64'd0);
    chk("mr_busy",   64'(ks_busy), 64'd0);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (k16_complete || ks_busy) seen = 1'b1;
    end
    chk("mr_quiet", 64'(seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
